// File: rtl/disparity_wta.sv
// Winner-take-all disparity selector: serial per-candidate costs in, index of the minimum out.
// Optional uniqueness check enabled by defining WTA_UNIQUENESS_EN.
module disparity_wta #(
    parameter int NUM_DISP    = 64,
    parameter int COST_W      = 16,
    parameter int UNIQ_MARGIN = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              valid_in,
    input  logic              first_in,
    input  logic [COST_W-1:0] cost_in,
    output logic              valid_out,
    output logic [5:0]        data_out,
    output logic              sweep_err
);

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(NUM_DISP - 1);

    state_t            state, state_n;
    logic [5:0]        d_cnt, d_cnt_n;
    logic [5:0]        best_idx, best_idx_n;
    logic [COST_W-1:0] best_cost, best_cost_n;
    logic [5:0]        data_n;
    logic              valid_n, err_n;

`ifdef WTA_UNIQUENESS_EN
    localparam logic [COST_W-1:0] MARGIN = COST_W'(UNIQ_MARGIN);
    logic [COST_W-1:0] second_cost, second_cost_n;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            d_cnt     <= '0;
            best_idx  <= '0;
            best_cost <= '1;
            valid_out <= 1'b0;
            data_out  <= '0;
            sweep_err <= 1'b0;
        end else begin
            state     <= state_n;
            d_cnt     <= d_cnt_n;
            best_idx  <= best_idx_n;
            best_cost <= best_cost_n;
            valid_out <= valid_n;
            data_out  <= data_n;
            sweep_err <= err_n;
        end
    end

`ifdef WTA_UNIQUENESS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) second_cost <= '1;
        else       second_cost <= second_cost_n;
    end
`endif

    always_comb begin
        state_n     = state;
        d_cnt_n     = d_cnt;
        best_idx_n  = best_idx;
        best_cost_n = best_cost;
        data_n      = data_out;
        valid_n     = 1'b0;
        err_n       = 1'b0;
`ifdef WTA_UNIQUENESS_EN
        second_cost_n = second_cost;
`endif
        if (valid_in) begin
            if (first_in) begin
                // A new sweep always wins; a half-finished one is dropped and flagged.
                err_n       = (state == SWEEP) && (d_cnt != 6'd0);
                best_cost_n = cost_in;
                best_idx_n  = 6'd0;
                d_cnt_n     = 6'd1;
                state_n     = SWEEP;
`ifdef WTA_UNIQUENESS_EN
                second_cost_n = '1;
`endif
            end else if (state == SWEEP) begin
                if (cost_in < best_cost) begin
                    best_cost_n = cost_in;
                    best_idx_n  = d_cnt;
`ifdef WTA_UNIQUENESS_EN
                    second_cost_n = best_cost;
                end else if (cost_in < second_cost) begin
                    second_cost_n = cost_in;
`endif
                end
                if (d_cnt == LAST_IDX) begin
                    valid_n = 1'b1;
                    data_n  = best_idx_n;
`ifdef WTA_UNIQUENESS_EN
                    if ((second_cost_n - best_cost_n) < MARGIN) data_n = 6'd0;
`endif
                    d_cnt_n = 6'd0;
                    state_n = IDLE;
                end else begin
                    d_cnt_n = d_cnt + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_disparity_wta.sv
// Directed self-checking bench for disparity_wta (default NUM_DISP=64, COST_W=16).
module tb_disparity_wta;

    logic        clock    = 1'b0;
    logic        reset    = 1'b1;
    logic        valid_in = 1'b0;
    logic        first_in = 1'b0;
    logic [15:0] cost_in  = '0;
    logic        valid_out;
    logic [5:0]  data_out;
    logic        sweep_err;

    int compared   = 0;
    int mismatched = 0;
    int vo_count   = 0;
    int err_count  = 0;

    logic [15:0] costs [64];

    disparity_wta dut (
        .clock    (clock),
        .reset    (reset),
        .valid_in (valid_in),
        .first_in (first_in),
        .cost_in  (cost_in),
        .valid_out(valid_out),
        .data_out (data_out),
        .sweep_err(sweep_err)
    );

    always #5 clock = ~clock;

    // Strobe counters sampled mid-cycle, away from the active edge.
    always @(negedge clock) begin
        if (valid_out === 1'b1) vo_count++;
        if (sweep_err === 1'b1) err_count++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_beat(input logic first, input logic [15:0] cost);
        valid_in = 1'b1;
        first_in = first;
        cost_in  = cost;
        tick();
    endtask

    task automatic fill(input logic [15:0] base, input int idx, input logic [15:0] val);
        for (int i = 0; i < 64; i++) costs[i] = base;
        costs[idx] = val;
    endtask

    task automatic run_sweep(input bit gaps);
        for (int d = 0; d < 64; d++) begin
            if (gaps && d != 0 && $urandom_range(0, 2) == 0) begin
                valid_in = 1'b0;
                first_in = 1'b0;
                repeat ($urandom_range(1, 3)) tick();
            end
            send_beat(d == 0, costs[d]);
        end
        valid_in = 1'b0;
        first_in = 1'b0;
    endtask

    task automatic partial(input int n);
        for (int d = 0; d < n; d++) send_beat(d == 0, 16'd500);
        valid_in = 1'b0;
        first_in = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) tick();
        compared++;
        if (valid_out !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_valid: got %0b expected 0", valid_out);
        end
        compared++;
        if (data_out !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: got %0d expected 0", data_out);
        end
        compared++;
        if (sweep_err !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL reset_err: got %0b expected 0", sweep_err);
        end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_idle_discard();
        int base = vo_count;
        for (int i = 0; i < 4; i++) send_beat(1'b0, 16'd0);
        valid_in = 1'b0;
        tick();
        compared++;
        if (vo_count - base !== 0) begin
            mismatched++;
            $display("[TB] FAIL idle_discard_strobes: got %0d expected 0", vo_count - base);
        end
    endtask

    task automatic test_descending();
        int base = vo_count;
        for (int d = 0; d < 64; d++) costs[d] = 16'(100 - d);
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd63) begin
            mismatched++;
            $display("[TB] FAIL desc_result: got v=%0b d=%0d expected v=1 d=63", valid_out, data_out);
        end
        tick();
        compared++;
        if (valid_out !== 1'b0 || data_out !== 6'd63) begin
            mismatched++;
            $display("[TB] FAIL desc_hold: got v=%0b d=%0d expected v=0 d=63", valid_out, data_out);
        end
        compared++;
        if (vo_count - base !== 1) begin
            mismatched++;
            $display("[TB] FAIL desc_strobes: got %0d expected 1", vo_count - base);
        end
    endtask

    task automatic test_flat();
        fill(16'd50, 0, 16'd50);
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL flat_tie: got v=%0b d=%0d expected v=1 d=0", valid_out, data_out);
        end
        tick();
        fill(16'hFFFF, 0, 16'hFFFF);
        costs[1] = 16'hFFFF;
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL all_ones: got v=%0b d=%0d expected v=1 d=0", valid_out, data_out);
        end
        tick();
    endtask

    task automatic test_gaps();
        int base = vo_count;
        fill(16'd200, 17, 16'd3);
        run_sweep(1'b1);
        compared++;
        if (vo_count - base !== 0) begin
            mismatched++;
            $display("[TB] FAIL gaps_early: got %0d expected 0", vo_count - base);
        end
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd17) begin
            mismatched++;
            $display("[TB] FAIL gaps_result: got v=%0b d=%0d expected v=1 d=17", valid_out, data_out);
        end
        tick();
        compared++;
        if (valid_out !== 1'b0 || vo_count - base !== 1) begin
            mismatched++;
            $display("[TB] FAIL gaps_single: got v=%0b n=%0d expected v=0 n=1", valid_out, vo_count - base);
        end
    endtask

    task automatic test_abort();
        int vbase = vo_count;
        int ebase = err_count;
        partial(20);
        fill(16'd300, 5, 16'd7);
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd5) begin
            mismatched++;
            $display("[TB] FAIL abort_result: got v=%0b d=%0d expected v=1 d=5", valid_out, data_out);
        end
        tick();
        compared++;
        if (err_count - ebase !== 1) begin
            mismatched++;
            $display("[TB] FAIL abort_err: got %0d expected 1", err_count - ebase);
        end
        compared++;
        if (vo_count - vbase !== 1) begin
            mismatched++;
            $display("[TB] FAIL abort_strobes: got %0d expected 1", vo_count - vbase);
        end
    endtask

    task automatic test_back_to_back();
        int vbase = vo_count;
        int ebase = err_count;
        fill(16'd400, 9, 16'd1);
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd9) begin
            mismatched++;
            $display("[TB] FAIL b2b_first: got v=%0b d=%0d expected v=1 d=9", valid_out, data_out);
        end
        fill(16'd400, 40, 16'd2);
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd40) begin
            mismatched++;
            $display("[TB] FAIL b2b_second: got v=%0b d=%0d expected v=1 d=40", valid_out, data_out);
        end
        tick();
        compared++;
        if (vo_count - vbase !== 2) begin
            mismatched++;
            $display("[TB] FAIL b2b_strobes: got %0d expected 2", vo_count - vbase);
        end
        compared++;
        if (err_count - ebase !== 0) begin
            mismatched++;
            $display("[TB] FAIL b2b_err: got %0d expected 0", err_count - ebase);
        end
    endtask

    task automatic test_mid_reset();
        int vbase = vo_count;
        int ebase = err_count;
        partial(30);
        reset = 1'b1;
        tick();
        compared++;
        if (valid_out !== 1'b0 || data_out !== 6'd0) begin
            mismatched++;
            $display("[TB] FAIL midrst_clear: got v=%0b d=%0d expected v=0 d=0", valid_out, data_out);
        end
        reset = 1'b0;
        tick();
        fill(16'd250, 2, 16'd9);
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd2) begin
            mismatched++;
            $display("[TB] FAIL midrst_result: got v=%0b d=%0d expected v=1 d=2", valid_out, data_out);
        end
        tick();
        compared++;
        if (vo_count - vbase !== 1 || err_count - ebase !== 0) begin
            mismatched++;
            $display("[TB] FAIL midrst_strobes: got v=%0d e=%0d expected v=1 e=0",
                     vo_count - vbase, err_count - ebase);
        end
    endtask

    task automatic test_uniqueness();
        logic [5:0] exp_close;
`ifdef WTA_UNIQUENESS_EN
        exp_close = 6'd0;
`else
        exp_close = 6'd12;
`endif
        fill(16'd200, 12, 16'd10);
        costs[30] = 16'd15;
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== exp_close) begin
            mismatched++;
            $display("[TB] FAIL uniq_close: got v=%0b d=%0d expected v=1 d=%0d", valid_out, data_out, exp_close);
        end
        tick();
        costs[30] = 16'd30;
        run_sweep(1'b0);
        compared++;
        if (valid_out !== 1'b1 || data_out !== 6'd12) begin
            mismatched++;
            $display("[TB] FAIL uniq_clear: got v=%0b d=%0d expected v=1 d=12", valid_out, data_out);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_idle_discard();
        test_descending();
        test_flat();
        test_gaps();
        test_abort();
        test_back_to_back();
        test_mid_reset();
        test_uniqueness();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/disparity_wta.md
Name: disparity_wta

Overview:
- Winner-take-all disparity selector. Sits directly upstream of the 6-bit-to-8-bit output decoder.
- Consumes one matching cost per cycle for a pixel's disparity candidates d = 0..NUM_DISP-1, presented serially.
- Emits the 6-bit index of the minimum-cost candidate, with a valid strobe, for the decoder to map to grey levels.

Parameters:
- NUM_DISP, 64, number of disparity candidates per pixel; legal range 2..64.
- COST_W, 16, width of the unsigned matching cost (SAD).
- UNIQ_MARGIN, 8, minimum gap between best and second-best cost. Used only with the optional feature.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- valid_in  input  1  cost_in/first_in are valid this cycle.
- first_in  input  1  qualifies the d = 0 cost of a new pixel sweep.
- cost_in  input  COST_W  unsigned matching cost for the current candidate.
- valid_out  output  1  one-cycle strobe: data_out holds a new disparity.
- data_out  output  6  winning disparity index.
- sweep_err  output  1  one-cycle strobe: a sweep was aborted by an early first_in.

Behaviour:
- Reset (asynchronous, active-high): valid_out=0, data_out=0, sweep_err=0, d_cnt=0, best_cost=all ones, best_idx=0, in_sweep=0.
- Internal state:
  - d_cnt: 6-bit candidate counter.
  - best_cost: COST_W bits.
  - best_idx: 6 bits.
  - in_sweep flag.
- Two states:
  - IDLE (in_sweep=0): waiting for first_in.
  - SWEEP (in_sweep=1): accumulating candidates.
- Cycles with valid_in=0 are stalls. All state holds, valid_out=0. Gaps of any length are allowed mid-sweep.
- IDLE with valid_in=1 and first_in=0: the beat is discarded, no state change.
- valid_in=1 and first_in=1, from either state:
  - best_cost<=cost_in, best_idx<=0, d_cnt<=1, go to SWEEP.
  - If already in SWEEP with d_cnt != 0, sweep_err pulses next cycle. The partial sweep is dropped and no valid_out is produced for it.
- SWEEP with valid_in=1 and first_in=0:
  - If cost_in < best_cost (strict): best_cost<=cost_in, best_idx<=d_cnt.
  - Ties keep the lower index.
  - d_cnt increments.
- Completion: the beat where d_cnt == NUM_DISP-1 is the last candidate.
  - That beat is included in the compare.
  - Next cycle: valid_out=1 and data_out=final best_idx.
  - d_cnt returns to 0 and the block returns to IDLE.
- Latency: valid_out asserts exactly 1 cycle after the last candidate beat.
- data_out holds its value between strobes. valid_out is never high on two consecutive cycles.
- A first_in arriving in the completion cycle itself (back-to-back pixels) is legal. It starts the next sweep with no bubble, and no sweep_err is raised.
- NUM_DISP=64: d_cnt reaches 63 and must not overflow into a false completion.
- Cost compare is full-width unsigned. A cost of all ones can still win if every candidate is all ones, in which case index 0 wins.
- Reset mid-sweep: the partial sweep is lost, nothing is emitted, and the block returns to IDLE.

Optional Feature:
- Macro: WTA_UNIQUENESS_EN.
- When defined, the block also tracks second_cost, the second-lowest cost over the sweep.
  - It resets and loads to all ones on first_in.
  - On a new best, second_cost takes the old best_cost.
  - Otherwise, if cost_in < second_cost, second_cost takes cost_in.
  - At completion: if (second_cost - best_cost) < UNIQ_MARGIN, data_out=0 (invalid/far), otherwise best_idx. valid_out timing is unchanged.
- When not defined, second_cost logic is absent and data_out is always best_idx.

Test Plan:
- Sweep with costs 100-d (d=0..63), no gaps → valid_out pulses once, 1 cycle after the d=63 beat, with data_out=63.
- Flat costs, all 50 → data_out=0 (tie keeps the lowest index).
- Minimum 3 at d=17, others 200, with random valid_in gaps inserted → data_out=17, and valid_out occurs exactly 1 cycle after the 64th valid beat.
- first_in reasserted at d=20 mid-sweep, then a full sweep with minimum at d=5 → sweep_err=1 for one cycle, exactly one valid_out, data_out=5.
- Two back-to-back sweeps (minima at d=9 and d=40) with first_in in the completion cycle → valid_out at both ends, data_out=9 then 40, no sweep_err.
- Reset asserted at d=30, then a full sweep with minimum at d=2 → no output for the aborted sweep, then data_out=2.
- With WTA_UNIQUENESS_EN: best=10 at d=12, second=15, UNIQ_MARGIN=8 → data_out=0. Same sweep with second=30 → data_out=12.
